// File: rtl/axis_uart_pkg.sv
// Shared types and constants for the UART TX arbitration slice.
package axis_uart_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_HEADER = 2'd1,
      ARB_DATA   = 2'd2
   } arb_state_t;

   localparam logic [3:0] HEADER_MARK = 4'hA;

   // Channel-ID header byte: marker nibble over the source index.
   function automatic logic [7:0] header_byte(input logic [3:0] id);
      return {HEADER_MARK, id};
   endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle (no tlast) used toward the UART transmitter.
interface axis_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;

   modport m_axis (output tvalid, output tdata, input tready);
   modport s_axis (input tvalid, input tdata, output tready);
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_picker #(
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0]         req,
   input  logic [$clog2(NUM_SRC)-1:0] last_grant,
   output logic                       found,
   output logic [$clog2(NUM_SRC)-1:0] idx
);
   localparam int IDX_W = $clog2(NUM_SRC);

   // Scan farthest-to-nearest so the nearest requester is the final winner.
   always_comb begin
      logic [IDX_W-1:0] cand_s;
      cand_s = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         cand_s = IDX_W'((int'(last_grant) + k) % NUM_SRC);
         found  = found | req[cand_s];
         idx    = req[cand_s] ? cand_s : idx;
      end
   end

endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX stream among NUM_SRC packet sources,
// with optional channel-ID header per grant, burst limit and stall watchdog.
module axis_uart_tx_arbiter
   import axis_uart_pkg::*;
#(
   parameter int NUM_SRC        = 4,
   parameter int AXI_DATA_WIDTH = 8,
   parameter bit HEADER_EN      = 1'b1,
   parameter int MAX_BURST      = 16,
   parameter int STALL_CYCLES   = 100_000
) (
   input  logic                               aclk,
   input  logic                               aresetn,
   input  logic [NUM_SRC-1:0]                 s_tvalid,
   output logic [NUM_SRC-1:0]                 s_tready,
   input  logic [NUM_SRC*AXI_DATA_WIDTH-1:0]  s_tdata,
   input  logic [NUM_SRC-1:0]                 s_tlast,
   axis_if.m_axis                             m_axis,
   output logic                               grant_valid,
   output logic [$clog2(NUM_SRC)-1:0]         grant_id,
   output logic                               pkt_done,
   output logic                               stall_err
);
   localparam int IDX_W      = $clog2(NUM_SRC);
   localparam int BEAT_W     = $clog2(MAX_BURST + 1);
   localparam int STALL_W    = $clog2(STALL_CYCLES + 1);
   localparam int BURST_LAST = MAX_BURST - 1;
   localparam int STALL_LAST = STALL_CYCLES - 1;

   arb_state_t                  state_r;
   logic                        grant_valid_r;
   logic [IDX_W-1:0]            grant_id_r;
   logic [IDX_W-1:0]            last_grant_r;
   logic [BEAT_W-1:0]           beat_cnt_r;
   logic [STALL_W-1:0]          stall_cnt_r;
   logic                        pkt_done_r;
   logic                        stall_err_r;

   logic                        pick_found_s;
   logic [IDX_W-1:0]            pick_idx_s;
   logic                        src_valid_s;
   logic                        src_last_s;
   logic [AXI_DATA_WIDTH-1:0]   src_data_s;
   logic                        hs_s;
   logic                        m_tvalid_s;
   logic [AXI_DATA_WIDTH-1:0]   m_tdata_s;
   logic [NUM_SRC-1:0]          s_tready_s;

   rr_picker #(
      .NUM_SRC (NUM_SRC)
   ) u_picker (
      .req        (s_tvalid),
      .last_grant (last_grant_r),
      .found      (pick_found_s),
      .idx        (pick_idx_s)
   );

   assign src_valid_s = s_tvalid[grant_id_r];
   assign src_last_s  = s_tlast[grant_id_r];
   assign src_data_s  = s_tdata[int'(grant_id_r) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
   assign hs_s        = (state_r == ARB_DATA) && src_valid_s && m_axis.tready;

   // Output steering: header from registered grant, data straight from the owner.
   always_comb begin
      m_tvalid_s = 1'b0;
      m_tdata_s  = '0;
      s_tready_s = '0;
      case (state_r)
         ARB_HEADER: begin
            m_tvalid_s = 1'b1;
            m_tdata_s  = AXI_DATA_WIDTH'(header_byte(4'(grant_id_r)));
         end
         ARB_DATA: begin
            m_tvalid_s             = src_valid_s;
            m_tdata_s              = src_data_s;
            s_tready_s[grant_id_r] = m_axis.tready;
         end
         default: begin
            m_tvalid_s = 1'b0;
            m_tdata_s  = '0;
            s_tready_s = '0;
         end
      endcase
   end

   assign m_axis.tvalid = m_tvalid_s;
   assign m_axis.tdata  = m_tdata_s;
   assign s_tready      = s_tready_s;
   assign grant_valid   = grant_valid_r;
   assign grant_id      = grant_id_r;
   assign pkt_done      = pkt_done_r;
   assign stall_err     = stall_err_r;

   // Arbitration FSM with grant bookkeeping, burst counter and stall watchdog.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_r       <= ARB_IDLE;
         grant_valid_r <= 1'b0;
         grant_id_r    <= '0;
         last_grant_r  <= IDX_W'(NUM_SRC - 1);
         beat_cnt_r    <= '0;
         stall_cnt_r   <= '0;
         pkt_done_r    <= 1'b0;
         stall_err_r   <= 1'b0;
      end else begin
         pkt_done_r  <= 1'b0;
         stall_err_r <= 1'b0;
         case (state_r)
            ARB_IDLE: begin
               if (pick_found_s) begin
                  grant_id_r    <= pick_idx_s;
                  grant_valid_r <= 1'b1;
                  last_grant_r  <= pick_idx_s;
                  state_r       <= HEADER_EN ? ARB_HEADER : ARB_DATA;
               end
            end
            ARB_HEADER: begin
               if (m_axis.tready) begin
                  state_r <= ARB_DATA;
               end
            end
            ARB_DATA: begin
               // tlast wins over the burst limit when both land on one beat.
               if (hs_s) begin
                  stall_cnt_r <= '0;
                  if (src_last_s || (beat_cnt_r == BEAT_W'(BURST_LAST))) begin
                     pkt_done_r    <= src_last_s;
                     state_r       <= ARB_IDLE;
                     grant_valid_r <= 1'b0;
                     beat_cnt_r    <= '0;
                  end else begin
                     beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                  end
               end else if (src_valid_s) begin
                  stall_cnt_r <= '0;
               end else if (stall_cnt_r == STALL_W'(STALL_LAST)) begin
                  stall_err_r   <= 1'b1;
                  state_r       <= ARB_IDLE;
                  grant_valid_r <= 1'b0;
                  beat_cnt_r    <= '0;
                  stall_cnt_r   <= '0;
               end else begin
                  stall_cnt_r <= stall_cnt_r + STALL_W'(1);
               end
            end
            default: begin
               state_r       <= ARB_IDLE;
               grant_valid_r <= 1'b0;
               beat_cnt_r    <= '0;
               stall_cnt_r   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Self-checking bench: arbitration table, directed corner sequences and a
// randomized run against a queue-level round-robin reference model.
module tb_axis_uart_tx_arbiter;
   localparam int NS    = 4;
   localparam int W     = 8;
   localparam int MAXB  = 16;
   localparam int DEPTH = 256;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   logic [NS-1:0]   s_tvalid = '0;
   logic [NS-1:0]   s_tlast = '0;
   logic [NS*W-1:0] s_tdata = '0;
   logic            m_tready = 1'b0;
   logic [NS-1:0]   s_tready_a, s_tready_b;
   logic            gv_a, gv_b, pd_a, pd_b, se_a, se_b;
   logic [1:0]      gid_a, gid_b;

   axis_if #(.DATA_WIDTH(W)) m_a ();
   axis_if #(.DATA_WIDTH(W)) m_b ();
   assign m_a.tready = m_tready;
   assign m_b.tready = m_tready;

   axis_uart_tx_arbiter #(.NUM_SRC(NS), .AXI_DATA_WIDTH(W), .HEADER_EN(1'b1),
                          .MAX_BURST(MAXB), .STALL_CYCLES(100)) dut_a (
      .aclk(aclk), .aresetn(aresetn), .s_tvalid(s_tvalid), .s_tready(s_tready_a),
      .s_tdata(s_tdata), .s_tlast(s_tlast), .m_axis(m_a), .grant_valid(gv_a),
      .grant_id(gid_a), .pkt_done(pd_a), .stall_err(se_a));

   axis_uart_tx_arbiter #(.NUM_SRC(NS), .AXI_DATA_WIDTH(W), .HEADER_EN(1'b0),
                          .MAX_BURST(MAXB), .STALL_CYCLES(100)) dut_b (
      .aclk(aclk), .aresetn(aresetn), .s_tvalid(s_tvalid), .s_tready(s_tready_b),
      .s_tdata(s_tdata), .s_tlast(s_tlast), .m_axis(m_b), .grant_valid(gv_b),
      .grant_id(gid_b), .pkt_done(pd_b), .stall_err(se_b));

   always #5 aclk = ~aclk;

   // Source packet storage: {last, data} per beat.
   logic [8:0] mem [NS][DEPTH];
   int head [NS];
   int tail [NS];
   int pops [NS];
   int stop_at [NS];

   logic [7:0] act_q[$];
   logic [7:0] exp_q[$];
   int gid_q[$];
   int exp_gid[$];
   int done_cyc[$];
   int done_cnt, stall_seen, stall_cyc, exp_done, cyc;
   int n_tests = 0;
   int n_fail = 0;
   bit sel_b, rand_rdy, force_rdy, prev_gv;
   logic cur_tv, cur_gv, cur_pd, cur_se;
   logic [7:0] cur_td;
   logic [1:0] cur_gid;
   logic [NS-1:0] cur_rdy;

   typedef struct packed {
      logic [3:0] mask;
      logic [7:0] base;
      logic [1:0] gid;
   } vec_t;
   vec_t vecs [10];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_logs();
      act_q.delete(); exp_q.delete(); gid_q.delete(); exp_gid.delete(); done_cyc.delete();
      done_cnt = 0; stall_seen = 0; stall_cyc = -1; exp_done = 0; prev_gv = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge aclk);
      aresetn = 1'b0; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
      rand_rdy = 1'b0; force_rdy = 1'b1;
      for (int i = 0; i < NS; i++) begin
         head[i] = 0; tail[i] = 0; pops[i] = 0; stop_at[i] = -1;
         for (int j = 0; j < DEPTH; j++) mem[i][j] = '0;
      end
      clear_logs();
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
   endtask

   task automatic add_pkt(input int src, input int len, input bit rnd, input logic [7:0] base);
      for (int b = 0; b < len; b++) begin
         logic [7:0] d;
         d = rnd ? 8'($urandom) : base + 8'(b);
         mem[src][tail[src]] = {(b == len - 1), d};
         tail[src]++;
      end
   endtask

   function automatic bit all_empty();
      bit e;
      e = 1'b1;
      for (int i = 0; i < NS; i++) if (head[i] != tail[i]) e = 1'b0;
      return e;
   endfunction

   // One clock: drive sources from their queues, then observe just before the edge.
   task automatic step();
      @(negedge aclk);
      for (int i = 0; i < NS; i++) begin
         logic [8:0] w;
         w = mem[i][head[i]];
         s_tvalid[i] = (head[i] != tail[i]) && (pops[i] != stop_at[i]);
         s_tdata[i*W +: W] = w[7:0];
         s_tlast[i] = w[8];
      end
      m_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
      #1;
      cyc++;
      cur_tv  = sel_b ? m_b.tvalid : m_a.tvalid;
      cur_td  = sel_b ? m_b.tdata  : m_a.tdata;
      cur_gv  = sel_b ? gv_b  : gv_a;
      cur_gid = sel_b ? gid_b : gid_a;
      cur_pd  = sel_b ? pd_b  : pd_a;
      cur_se  = sel_b ? se_b  : se_a;
      cur_rdy = sel_b ? s_tready_b : s_tready_a;
      if (cur_tv && m_tready) act_q.push_back(cur_td);
      if (cur_gv && !prev_gv) gid_q.push_back(int'(cur_gid));
      prev_gv = cur_gv;
      if (cur_pd) begin done_cnt++; done_cyc.push_back(cyc); end
      if (cur_se) begin stall_seen++; stall_cyc = cyc; end
      for (int i = 0; i < NS; i++)
         if (s_tvalid[i] && cur_rdy[i]) begin head[i]++; pops[i]++; end
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      do begin step(); n++; end while ((!all_empty() || cur_gv) && n < budget);
      chk({tag, "_drained"}, int'(n < budget), 1);
      repeat (2) step();
   endtask

   // Reference: round-robin over sources with pending beats, one packet or MAXB beats per turn.
   task automatic build_model(input bit hdr);
      int h [NS];
      int last, pick;
      last = NS - 1;
      for (int i = 0; i < NS; i++) h[i] = head[i];
      for (int guard = 0; guard < 1000; guard++) begin
         pick = -1;
         for (int k = 1; k <= NS; k++)
            if (pick < 0 && h[(last + k) % NS] != tail[(last + k) % NS]) pick = (last + k) % NS;
         if (pick < 0) break;
         last = pick;
         exp_gid.push_back(pick);
         if (hdr) exp_q.push_back(8'hA0 | 8'(pick));
         for (int b = 0; b < MAXB; b++) begin
            logic [8:0] w;
            w = mem[pick][h[pick]];
            h[pick]++;
            exp_q.push_back(w[7:0]);
            if (w[8]) begin exp_done++; break; end
         end
      end
   endtask

   task automatic cmp(input string tag, input int exp_stall);
      chk({tag, "_nbeats"}, act_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
         if (k < act_q.size()) chk($sformatf("%s_beat%0d", tag, k), int'(act_q[k]), int'(exp_q[k]));
      chk({tag, "_ngrants"}, gid_q.size(), exp_gid.size());
      for (int k = 0; k < exp_gid.size(); k++)
         if (k < gid_q.size()) chk($sformatf("%s_gid%0d", tag, k), gid_q[k], exp_gid[k]);
      chk({tag, "_pkt_done"}, done_cnt, exp_done);
      chk({tag, "_stall_err"}, stall_seen, exp_stall);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n, fall, bad;
      cyc = 0; sel_b = 1'b0;
      vecs[0] = '{4'b1111, 8'h10, 2'd0};
      vecs[1] = '{4'b1111, 8'h20, 2'd1};
      vecs[2] = '{4'b0001, 8'h30, 2'd0};
      vecs[3] = '{4'b1001, 8'h40, 2'd3};
      vecs[4] = '{4'b1001, 8'h50, 2'd0};
      vecs[5] = '{4'b0110, 8'h60, 2'd1};
      vecs[6] = '{4'b0010, 8'h70, 2'd1};
      vecs[7] = '{4'b0100, 8'h80, 2'd2};
      vecs[8] = '{4'b1011, 8'h90, 2'd3};
      vecs[9] = '{4'b0100, 8'hB0, 2'd2};

      // Reset values.
      repeat (3) @(negedge aclk);
      #1;
      chk("rst_tvalid", int'(m_a.tvalid), 0);
      chk("rst_tdata", int'(m_a.tdata), 0);
      chk("rst_s_tready", int'(s_tready_a), 0);
      chk("rst_grant_valid", int'(gv_a), 0);
      chk("rst_grant_id", int'(gid_a), 0);
      chk("rst_pkt_done", int'(pd_a), 0);
      chk("rst_stall_err", int'(se_a), 0);

      // Table: request masks with expected round-robin winners.
      do_reset();
      for (int v = 0; v < 10; v++) begin
         @(negedge aclk);
         s_tvalid = vecs[v].mask; s_tlast = '1; m_tready = 1'b1;
         for (int i = 0; i < NS; i++) s_tdata[i*W +: W] = vecs[v].base + 8'(i);
         @(negedge aclk);
         s_tvalid = 4'b0001 << vecs[v].gid;
         #1;
         chk($sformatf("tab%0d_grant_id", v), int'(gid_a), int'(vecs[v].gid));
         chk($sformatf("tab%0d_grant_valid", v), int'(gv_a), 1);
         chk($sformatf("tab%0d_hdr", v), int'({m_a.tvalid, m_a.tdata}), int'({1'b1, 8'hA0 | 8'(vecs[v].gid)}));
         @(negedge aclk);
         #1;
         chk($sformatf("tab%0d_data", v), int'(m_a.tdata), int'(vecs[v].base + 8'(vecs[v].gid)));
         chk($sformatf("tab%0d_s_tready", v), int'(s_tready_a), int'(4'b0001 << vecs[v].gid));
         @(negedge aclk);
         s_tvalid = '0;
         #1;
         chk($sformatf("tab%0d_pkt_done", v), int'(pd_a), 1);
         chk($sformatf("tab%0d_release", v), int'(gv_a), 0);
      end

      // Four single-beat sources served in order 0..3.
      do_reset();
      for (int i = 0; i < NS; i++) begin
         add_pkt(i, 1, 1'b0, 8'h10 + 8'(i));
         exp_q.push_back(8'hA0 | 8'(i)); exp_q.push_back(8'h10 + 8'(i)); exp_gid.push_back(i);
      end
      exp_done = 4;
      drain("rr4", 200);
      cmp("rr4", 0);

      // 20-beat packet split at the burst limit with a fresh header.
      do_reset();
      add_pkt(2, 20, 1'b0, 8'h00);
      exp_q.push_back(8'hA2);
      for (int b = 0; b < 16; b++) exp_q.push_back(8'(b));
      exp_q.push_back(8'hA2);
      for (int b = 16; b < 20; b++) exp_q.push_back(8'(b));
      exp_gid.push_back(2); exp_gid.push_back(2); exp_done = 1;
      drain("burst", 200);
      cmp("burst", 0);

      // Header held under 50 cycles of backpressure.
      do_reset();
      add_pkt(1, 1, 1'b0, 8'h55);
      force_rdy = 1'b0;
      step();
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         step();
         if (cur_tv !== 1'b1 || cur_td !== 8'hA1) bad++;
      end
      chk("hdr_hold_unstable_cycles", bad, 0);
      chk("hdr_hold_stall_err", stall_seen, 0);
      force_rdy = 1'b1;
      exp_q.push_back(8'hA1); exp_q.push_back(8'h55); exp_gid.push_back(1); exp_done = 1;
      drain("hdr_hold", 100);
      cmp("hdr_hold", 0);

      // Watchdog: source 1 stops after three beats, source 3 waiting.
      do_reset();
      add_pkt(1, 6, 1'b0, 8'h30);
      add_pkt(3, 1, 1'b0, 8'h77);
      stop_at[1] = 3;
      fall = -1; n = 0;
      while (stall_seen == 0 && n < 400) begin
         step(); n++;
         if (pops[1] == 3 && fall < 0) fall = cyc + 1;
      end
      chk("wd_latency", stall_cyc - fall, 100);
      n = 0;
      while ((head[3] != tail[3] || cur_gv) && n < 50) begin step(); n++; end
      stop_at[1] = -1;
      drain("wd", 200);
      exp_q = '{8'hA1, 8'h30, 8'h31, 8'h32, 8'hA3, 8'h77, 8'hA1, 8'h33, 8'h34, 8'h35};
      exp_gid = '{1, 3, 1};
      exp_done = 2;
      cmp("wd", 1);

      // Reset in the middle of a data grant on source 0.
      do_reset();
      add_pkt(0, 5, 1'b0, 8'h40);
      add_pkt(1, 1, 1'b0, 8'h88);
      n = 0;
      while (pops[0] < 2 && n < 20) begin step(); n++; end
      @(negedge aclk);
      aresetn = 1'b0;
      @(negedge aclk);
      #1;
      chk("midrst_s_tready", int'(s_tready_a), 0);
      chk("midrst_tvalid", int'(m_a.tvalid), 0);
      chk("midrst_grant_valid", int'(gv_a), 0);
      aresetn = 1'b1;
      clear_logs();
      drain("midrst", 100);
      exp_q = '{8'hA0, 8'h42, 8'h43, 8'h44, 8'hA1, 8'h88};
      exp_gid = '{0, 1};
      exp_done = 2;
      cmp("midrst", 0);

      // Randomized packets with random UART backpressure versus the reference model.
      do_reset();
      for (int i = 0; i < NS; i++)
         for (int p = 0; p < 6; p++) add_pkt(i, $urandom_range(1, 20), 1'b1, 8'h00);
      build_model(1'b1);
      rand_rdy = 1'b1;
      drain("rand", 5000);
      cmp("rand", 0);

      // Header-less instance: continuous 3-beat packets from source 1.
      sel_b = 1'b1;
      do_reset();
      for (int p = 0; p < 3; p++) add_pkt(1, 3, 1'b1, 8'h00);
      build_model(1'b0);
      drain("nohdr", 100);
      cmp("nohdr", 0);
      chk("nohdr_done_pulses", done_cyc.size(), 3);
      if (done_cyc.size() >= 3) begin
         chk("nohdr_period0", done_cyc[1] - done_cyc[0], 4);
         chk("nohdr_period1", done_cyc[2] - done_cyc[1], 4);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_uart_tx_arbiter.md
Name: axis_uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmit datapath (an AXI-Stream slave accepting one frame per beat) among NUM_SRC AXI-Stream packet sources.
- Each grant is locked for one packet (until tlast) or until MAX_BURST beats have been accepted, whichever comes first.
- Each grant is optionally preceded by a channel-ID header beat so the far end can demultiplex.
- A per-grant stall watchdog frees the UART if a granted source stops supplying data mid-packet.

Parameters:
NUM_SRC, 4, number of requesters (2..16)
AXI_DATA_WIDTH, 8, beat width; multiple of 8
HEADER_EN, 1, 1 = emit header beat at start of every grant
MAX_BURST, 16, max data beats per grant (>=1)
STALL_CYCLES, 100_000, cycles a granted source may hold tvalid low inside a packet before forced release

Ports:
aclk  input  1  clock
aresetn  input  1  synchronous active-low reset
s_tvalid  input  NUM_SRC  per-source valid
s_tready  output  NUM_SRC  per-source ready
s_tdata  input  NUM_SRC*AXI_DATA_WIDTH  source i occupies bits [i*W +: W]
s_tlast  input  NUM_SRC  per-source end of packet
m_axis  axis_if.m_axis  -  toward UART TX (tvalid, tready, tdata)
grant_valid  output  1  a source currently owns the UART
grant_id  output  $clog2(NUM_SRC)  owning source
pkt_done  output  1  one-cycle pulse: grant ended on tlast
stall_err  output  1  one-cycle pulse: grant ended by watchdog

Behaviour:
- Clock and reset: aclk; aresetn is synchronous, active-low.
- Reset values:
  - state ARB_IDLE; all s_tready 0; m_axis.tvalid 0; m_axis.tdata 0.
  - grant_valid 0, grant_id 0, pkt_done 0, stall_err 0.
  - last_grant = NUM_SRC-1, so the first search starts at source 0.
  - Beat and stall counters 0.
- State machine:
  - ARB_IDLE:
    - Each cycle, pick the first i with s_tvalid[i]=1, searching from last_grant+1 modulo NUM_SRC.
    - If a source is found: register grant_id=i, grant_valid=1, last_grant=i. Go to ARB_HEADER if HEADER_EN, else ARB_DATA. Arbitration latency is 1 cycle.
    - No s_tready is asserted in IDLE.
  - ARB_HEADER:
    - m_axis.tvalid=1, m_axis.tdata = {zeros, 4'hA, grant_id padded to 4 bits}; all s_tready 0.
    - On m_axis.tready, go to ARB_DATA.
    - The header is never withdrawn once presented.
  - ARB_DATA (combinational pass-through for the granted source only):
    - m_axis.tvalid = s_tvalid[g]; m_axis.tdata = s_tdata[g]; s_tready[g] = m_axis.tready; other s_tready 0.
    - Each handshake increments beat_cnt.
    - Handshake with s_tlast[g]=1: pulse pkt_done, go to ARB_IDLE.
    - Handshake that makes beat_cnt == MAX_BURST without tlast: go to ARB_IDLE, no pulse. The rest of the packet is re-arbitrated and gets a fresh header.
    - Leaving DATA clears beat_cnt and stall_cnt and drops grant_valid.
- Watchdog:
  - In ARB_DATA, stall_cnt increments while s_tvalid[g]=0 and clears on s_tvalid[g]=1.
  - At stall_cnt == STALL_CYCLES-1: pulse stall_err, go to ARB_IDLE.
  - Stall time while m_axis.tready=0 with valid high is not counted; the UART backpressure is legitimate.
- Simultaneous events:
  - Handshake with tlast on the same cycle the beat limit is hit: pkt_done pulses and tlast takes priority.
  - New requests arriving during a grant wait; no pre-emption.
  - A source requesting back-to-back is served again only after every other pending source has had a turn.
- Watchdog re-grant: after a stall_err, the stalled source is eligible again, but last_grant has already advanced past it.
- Reset mid-grant returns everything to the reset state within one cycle. The beat in flight is dropped; the source must resend.
- AXI rules:
  - m_axis.tvalid is never deasserted before tready in HEADER.
  - In DATA, valid follows the source, which owns AXIS stability.
- Output registering: grant_valid, grant_id, pkt_done, stall_err are registered.

Decomposition:
- Package axis_uart_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_HEADER, ARB_DATA}
  - HEADER_MARK = 4'hA
- Sub-module rr_picker (combinational): inputs req[NUM_SRC] and last_grant; outputs found and idx. It is reused by the future RX demux and by the config-bus scheduler.

Test Plan:
- Sources 0..3 all valid after reset, 1-beat packets, tready=1 → header/data pairs 0xA0,d0,0xA1,d1,0xA2,d2,0xA3,d3; four pkt_done pulses; grant_id sequence 0,1,2,3.
- Source 2 sends a 20-beat packet, MAX_BURST=16 → header 0xA2 + 16 beats; IDLE; header 0xA2 + 4 beats with pkt_done on the last; no pkt_done after beat 16.
- tready held 0 for 50 cycles during HEADER → tvalid stays 1, tdata stable at 0xA1, no stall_err.
- Source 1 granted, drops tvalid after beat 3, STALL_CYCLES=100 → stall_err pulses exactly 100 cycles after tvalid fell; source 3 (waiting) granted next.
- aresetn asserted mid-DATA on source 0 → next cycle all s_tready=0, m_axis.tvalid=0, grant_valid=0; after release, with 0 and 1 requesting, source 0 is granted first.
- HEADER_EN=0, single source 1 streaming continuous 3-beat packets → data-only beats, 1 idle cycle between packets, pkt_done every 4th cycle.
